// File: rtl/de_pending_scoreboard.sv
// Decode-stage pending-write scoreboard: a saturating counter per register tracks in-flight writers.
// Optional same-cycle WB bypass of hazard/saturation checks is enabled by defining SCB_WB_BYPASS_EN.
module de_pending_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int REGNOBITS = 5,
  parameter int NUM_SRC   = 2,
  parameter int CNT_BITS  = 2,
  parameter int TOTBITS   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          issue_valid,
  input  logic                          issue_wr_reg,
  input  logic [REGNOBITS-1:0]          issue_rd,
  input  logic [NUM_SRC-1:0]            src_use,
  input  logic [NUM_SRC*REGNOBITS-1:0]  src_regno,
  input  logic                          br_mispred,
  input  logic                          wb_valid,
  input  logic [REGNOBITS-1:0]          wb_regno,
  output logic                          stall,
  output logic                          data_hazard,
  output logic                          sat_stall,
  output logic [NUM_REGS-1:0]           busy_vec,
  output logic [TOTBITS-1:0]            pending_total,
  output logic                          err_underflow
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [CNT_BITS-1:0] cnt     [NUM_REGS];
  logic [CNT_BITS-1:0] cnt_nxt [NUM_REGS];
  logic [CNT_BITS-1:0] src_cnt [NUM_SRC];
  logic [CNT_BITS-1:0] rd_cnt;
  logic [NUM_SRC-1:0]  src_haz;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [TOTBITS-1:0]  total_nxt;
  logic                uflow_nxt;
  logic                rel;
  logic                issue_fire;

  // Only r in 1..NUM_REGS-1 is ever probed, so reg 0 and out-of-range indices never match.
  function automatic logic idx_hit(input logic [REGNOBITS-1:0] idx, input int r);
    return idx == REGNOBITS'(r);
  endfunction

  function automatic logic is_saturated(input logic [CNT_BITS-1:0] c);
    return c == CNT_MAX;
  endfunction

  assign rel = wb_valid && (wb_regno != '0);

  always_comb begin
    rd_cnt = '0;
    for (int r = 1; r < NUM_REGS; r++)
      if (idx_hit(issue_rd, r)) rd_cnt = cnt[r];
    for (int i = 0; i < NUM_SRC; i++) begin
      src_cnt[i] = '0;
      for (int r = 1; r < NUM_REGS; r++)
        if (idx_hit(src_regno[i*REGNOBITS +: REGNOBITS], r)) src_cnt[i] = cnt[r];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_haz[i] = issue_valid && src_use[i] && (src_cnt[i] != '0);
`ifdef SCB_WB_BYPASS_EN
      // The last outstanding writer retires this cycle; the regfile writes on negedge.
      if (rel && (wb_regno == src_regno[i*REGNOBITS +: REGNOBITS]) && (src_cnt[i] == CNT_BITS'(1)))
        src_haz[i] = 1'b0;
`endif
    end
    sat_stall = issue_valid && issue_wr_reg && (issue_rd != '0) && is_saturated(rd_cnt);
`ifdef SCB_WB_BYPASS_EN
    if (rel && (wb_regno == issue_rd)) sat_stall = 1'b0;
`endif
  end

  assign data_hazard = |src_haz;
  assign stall       = data_hazard || sat_stall || br_mispred;
  assign issue_fire  = issue_valid && issue_wr_reg && (issue_rd != '0) && !stall;

  always_comb begin
    uflow_nxt = 1'b0;
    total_nxt = '0;
    busy_nxt  = '0;
    for (int r = 0; r < NUM_REGS; r++) cnt_nxt[r] = cnt[r];
    cnt_nxt[0] = '0;
    // Issue and release to the same register cancel, even when the counter is 0.
    for (int r = 1; r < NUM_REGS; r++) begin
      if (issue_fire && idx_hit(issue_rd, r) && !(rel && idx_hit(wb_regno, r)))
        cnt_nxt[r] = cnt[r] + 1'b1;
      else if (rel && idx_hit(wb_regno, r) && !(issue_fire && idx_hit(issue_rd, r))) begin
        if (cnt[r] != '0) cnt_nxt[r] = cnt[r] - 1'b1;
        else              uflow_nxt  = 1'b1;
      end
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_nxt[r] = |cnt_nxt[r];
      total_nxt   = total_nxt + TOTBITS'(cnt_nxt[r]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      busy_vec      <= '0;
      pending_total <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_nxt[r];
      busy_vec      <= busy_nxt;
      pending_total <= total_nxt;
      if (uflow_nxt) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_de_pending_scoreboard.sv
// Bench for de_pending_scoreboard: directed scenarios followed by random traffic against a counter-array model.
module tb_de_pending_scoreboard;

  localparam int NUM_REGS  = 32;
  localparam int REGNOBITS = 5;
  localparam int NUM_SRC   = 2;
  localparam int CNT_BITS  = 2;
  localparam int TOTBITS   = 8;
  localparam int MAXC      = (1 << CNT_BITS) - 1;

  logic                         clk;
  logic                         reset;
  logic                         issue_valid;
  logic                         issue_wr_reg;
  logic [REGNOBITS-1:0]         issue_rd;
  logic [NUM_SRC-1:0]           src_use;
  logic [NUM_SRC*REGNOBITS-1:0] src_regno;
  logic                         br_mispred;
  logic                         wb_valid;
  logic [REGNOBITS-1:0]         wb_regno;
  logic                         stall;
  logic                         data_hazard;
  logic                         sat_stall;
  logic [NUM_REGS-1:0]          busy_vec;
  logic [TOTBITS-1:0]           pending_total;
  logic                         err_underflow;

  de_pending_scoreboard #(
    .NUM_REGS(NUM_REGS), .REGNOBITS(REGNOBITS), .NUM_SRC(NUM_SRC),
    .CNT_BITS(CNT_BITS), .TOTBITS(TOTBITS)
  ) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_wr_reg(issue_wr_reg), .issue_rd(issue_rd),
    .src_use(src_use), .src_regno(src_regno), .br_mispred(br_mispred),
    .wb_valid(wb_valid), .wb_regno(wb_regno),
    .stall(stall), .data_hazard(data_hazard), .sat_stall(sat_stall),
    .busy_vec(busy_vec), .pending_total(pending_total), .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int m [NUM_REGS];
  bit m_err;
  bit exp_haz, exp_sat, exp_stall;
  int n_assert = 0;
  int n_fail   = 0;

`ifdef SCB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mc(input int idx);
    if (idx <= 0 || idx >= NUM_REGS) return 0;
    return m[idx];
  endfunction

  task automatic model_comb();
    bit rel;
    int s;
    rel = wb_valid && (int'(wb_regno) != 0);
    exp_haz = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s = int'(src_regno[i*REGNOBITS +: REGNOBITS]);
      if (issue_valid && src_use[i] && mc(s) != 0 &&
          !(BYP && rel && int'(wb_regno) == s && mc(s) == 1))
        exp_haz = 1'b1;
    end
    exp_sat = issue_valid && issue_wr_reg && int'(issue_rd) != 0 && mc(int'(issue_rd)) == MAXC &&
              !(BYP && rel && wb_regno == issue_rd);
    exp_stall = exp_haz || exp_sat || br_mispred;
  endtask

  task automatic mid_check();
    #3;
    model_comb();
    chk("stall", stall, exp_stall);
    chk("data_hazard", data_hazard, exp_haz);
    chk("sat_stall", sat_stall, exp_sat);
  endtask

  task automatic check_regs();
    logic [NUM_REGS-1:0] eb;
    int tot;
    eb = '0;
    tot = 0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (m[r] != 0) eb[r] = 1'b1;
      tot += m[r];
    end
    chk("busy_vec", busy_vec, eb);
    chk("pending_total", pending_total, tot);
    chk("err_underflow", err_underflow, m_err);
  endtask

  task automatic edge_update();
    bit fire, rel;
    int rd, wb;
    rd   = int'(issue_rd);
    wb   = int'(wb_regno);
    fire = issue_valid && issue_wr_reg && rd != 0 && !exp_stall;
    rel  = wb_valid && wb != 0;
    @(posedge clk);
    #1;
    if (!(fire && rel && rd == wb)) begin
      if (fire && rd < NUM_REGS) m[rd]++;
      if (rel && wb < NUM_REGS) begin
        if (m[wb] > 0) m[wb]--;
        else m_err = 1'b1;
      end
    end
    check_regs();
  endtask

  task automatic cycle();
    mid_check();
    edge_update();
  endtask

  task automatic idle();
    issue_valid = 0; issue_wr_reg = 0; issue_rd = '0; src_use = '0; src_regno = '0;
    br_mispred = 0; wb_valid = 0; wb_regno = '0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NUM_REGS; r++) m[r] = 0;
    m_err = 1'b0;
  endtask

  initial begin
    idle();
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_regs();
    chk("reset_stall", stall, 1'b0);
    reset = 1'b0;

    // Basic RAW on r5
    idle(); issue_valid = 1; issue_wr_reg = 1; issue_rd = 5;
    cycle();
    idle(); issue_valid = 1; src_use = 2'b01; src_regno[4:0] = 5;
    mid_check();
    chk("raw_stall", stall, 1'b1);
    chk("raw_hazard", data_hazard, 1'b1);
    chk("raw_busy5", busy_vec[5], 1'b1);
    edge_update();
    wb_valid = 1; wb_regno = 5;
    mid_check();
    chk("raw_wb_stall", stall, !BYP);
    edge_update();
    chk("raw_cnt_cleared", busy_vec[5], 1'b0);
    wb_valid = 0; wb_regno = 0;
    mid_check();
    chk("raw_after_wb_stall", stall, 1'b0);
    edge_update();

    // WAW saturation on r7
    idle(); issue_valid = 1; issue_wr_reg = 1; issue_rd = 7;
    repeat (3) cycle();
    chk("waw_total3", pending_total, 3);
    mid_check();
    chk("waw_sat", sat_stall, 1'b1);
    chk("waw_stall", stall, 1'b1);
    edge_update();
    chk("waw_total_held", pending_total, 3);

    // Same-register issue and release on r9
    idle(); issue_valid = 1; issue_wr_reg = 1; issue_rd = 9;
    cycle();
    wb_valid = 1; wb_regno = 9;
    cycle();
    chk("same_reg_total", pending_total, 4);
    chk("same_reg_busy9", busy_vec[9], 1'b1);
    chk("same_reg_err", err_underflow, 1'b0);

    // Underflow
    idle(); wb_valid = 1; wb_regno = 0;
    cycle();
    chk("wb0_noerr", err_underflow, 1'b0);
    wb_regno = 12;
    cycle();
    chk("uflow_set", err_underflow, 1'b1);
    idle();
    cycle();
    chk("uflow_held", err_underflow, 1'b1);

    // Mispredict blocks issue
    idle(); issue_valid = 1; issue_wr_reg = 1; issue_rd = 3; br_mispred = 1;
    mid_check();
    chk("mispred_stall", stall, 1'b1);
    edge_update();
    chk("mispred_busy3", busy_vec[3], 1'b0);

    // Asynchronous reset mid-cycle
    idle();
    chk("pre_reset_total", pending_total, 4);
    #2;
    reset = 1'b1;
    #1;
    chk("async_busy", busy_vec, '0);
    chk("async_total", pending_total, '0);
    chk("async_err", err_underflow, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Issue to r0 is ignored
    idle(); issue_valid = 1; issue_wr_reg = 1; issue_rd = 0;
    cycle();
    chk("rd0_total", pending_total, 0);

    // Random traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      issue_valid  = ($urandom_range(0, 3) != 0);
      issue_wr_reg = $urandom_range(0, 1);
      issue_rd     = REGNOBITS'($urandom_range(0, 7));
      src_use      = NUM_SRC'($urandom_range(0, 3));
      src_regno    = {REGNOBITS'($urandom_range(0, 7)), REGNOBITS'($urandom_range(0, 7))};
      br_mispred   = ($urandom_range(0, 7) == 0);
      wb_valid     = $urandom_range(0, 1);
      wb_regno     = REGNOBITS'($urandom_range(0, 7));
      cycle();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
